uart_frame_buffer: RTL and testbench

UART_FRAME_BUFFER -- requirements
Module: uart_frame_buffer

---
 rtl/uart_frame_pkg.sv | 5 +
 rtl/frame_mem.sv | 19 +
 rtl/uart_frame_buffer.sv | 95 +++++++++
 tb/tb_uart_frame_buffer.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/uart_frame_pkg.sv
// uart_frame_pkg: shared state encoding and byte width for the UART frame buffer.
package uart_frame_pkg;
  localparam int BYTE_W = 8;
  typedef enum logic [1:0] {COLLECT, SEND, HOLD, WAIT} state_e;
endpackage

// File: rtl/frame_mem.sv
// frame_mem: NBYTES x 8 register array, one write port, asynchronous read.
module frame_mem
  import uart_frame_pkg::*;
#(
  parameter int NBYTES = 4,
  parameter int AW = (NBYTES > 1) ? $clog2(NBYTES) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [BYTE_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [BYTE_W-1:0] rdata
);
  logic [BYTE_W-1:0] mem [NBYTES];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/uart_frame_buffer.sv
// uart_frame_buffer: collects received bytes into a frame and replays them to a UART transmitter.
module uart_frame_buffer
  import uart_frame_pkg::*;
#(
  parameter int NBYTES = 4,
  parameter int AUTO_PLAY = 0,
  parameter int CW = $clog2(NBYTES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [BYTE_W-1:0] rx_data,
  input  logic              clr,
  input  logic              play,
  input  logic              tx_busy,
  output logic              tx_start,
  output logic [BYTE_W-1:0] tx_data,
  output logic [CW-1:0]     count,
  output logic              frame_full,
  output logic              overflow,
  output logic              playing
);
  localparam int AW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  state_e state_q, state_d;
  logic [CW-1:0] count_q, count_d, rd_idx_q, rd_idx_d;
  logic overflow_q, overflow_d, tx_start_q, tx_start_d, we;
  logic [BYTE_W-1:0] tx_data_q, tx_data_d, rd_data;
  frame_mem #(.NBYTES(NBYTES), .AW(AW)) u_mem (
    .clk   (clk),
    .we    (we),
    .waddr (count_q[AW-1:0]),
    .wdata (rx_data),
    .raddr (rd_idx_q[AW-1:0]),
    .rdata (rd_data)
  );
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    rd_idx_d = rd_idx_q;
    overflow_d = overflow_q;
    tx_start_d = 1'b0;
    tx_data_d = tx_data_q;
    we = 1'b0;
    if (clr) begin
      state_d = COLLECT;
      count_d = '0;
      rd_idx_d = '0;
      overflow_d = 1'b0;
    end else if (state_q == COLLECT) begin
      we = rx_valid && count_q < CW'(NBYTES);
      count_d = we ? count_q + CW'(1) : count_q;
      overflow_d = overflow_q || (rx_valid && !we);
      // count_d already includes a same-cycle byte, so it joins the replay
      state_d = ((play && count_d != '0) || (AUTO_PLAY != 0 && count_d == CW'(NBYTES))) ? SEND : COLLECT;
    end else begin
      overflow_d = overflow_q || rx_valid;
      case (state_q)
        SEND: begin
          tx_start_d = !tx_busy;
          tx_data_d = tx_busy ? tx_data_q : rd_data;
          state_d = tx_busy ? SEND : HOLD;
        end
        HOLD: state_d = WAIT;
        default: if (!tx_busy) begin
          state_d = (rd_idx_q == count_q - CW'(1)) ? COLLECT : SEND;
          rd_idx_d = (state_d == COLLECT) ? '0 : rd_idx_q + CW'(1);
          count_d = (state_d == COLLECT) ? '0 : count_q;
        end
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= COLLECT;
      count_q <= '0;
      rd_idx_q <= '0;
      overflow_q <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rd_idx_q <= rd_idx_d;
      overflow_q <= overflow_d;
      tx_start_q <= tx_start_d;
      tx_data_q <= tx_data_d;
    end
  end
  assign tx_start = tx_start_q;
  assign tx_data = tx_data_q;
  assign count = count_q;
  assign frame_full = count_q == CW'(NBYTES);
  assign overflow = overflow_q;
  assign playing = state_q != COLLECT;
endmodule

// File: tb/tb_uart_frame_buffer.sv
// tb_uart_frame_buffer: directed checks of fill, replay, overflow, clear, reset and auto-play.
module tb_uart_frame_buffer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic a_rx_valid = 1'b0, a_clr = 1'b0, a_play = 1'b0, a_busy, a_tx_start, a_full, a_ovf, a_playing;
  logic [7:0] a_rx_data = 8'h00, a_tx_data;
  logic [2:0] a_count;
  logic b_rx_valid = 1'b0, b_clr = 1'b0, b_play = 1'b0, b_busy, b_tx_start, b_full, b_ovf, b_playing;
  logic [7:0] b_rx_data = 8'h00, b_tx_data;
  logic [1:0] b_count;
  int checks = 0, errors = 0;
  int a_bc = 0, b_bc = 0;
  logic [7:0] a_log[$], b_log[$];
  uart_frame_buffer #(.NBYTES(4), .AUTO_PLAY(0)) dut_a (
    .clk(clk), .rst(rst), .rx_valid(a_rx_valid), .rx_data(a_rx_data), .clr(a_clr),
    .play(a_play), .tx_busy(a_busy), .tx_start(a_tx_start), .tx_data(a_tx_data),
    .count(a_count), .frame_full(a_full), .overflow(a_ovf), .playing(a_playing)
  );
  uart_frame_buffer #(.NBYTES(2), .AUTO_PLAY(1)) dut_b (
    .clk(clk), .rst(rst), .rx_valid(b_rx_valid), .rx_data(b_rx_data), .clr(b_clr),
    .play(b_play), .tx_busy(b_busy), .tx_start(b_tx_start), .tx_data(b_tx_data),
    .count(b_count), .frame_full(b_full), .overflow(b_ovf), .playing(b_playing)
  );
  // transmitter model: busy for 10 cycles starting the cycle after each tx_start
  always @(posedge clk) begin
    a_bc <= a_tx_start ? 10 : (a_bc > 0 ? a_bc - 1 : 0);
    b_bc <= b_tx_start ? 10 : (b_bc > 0 ? b_bc - 1 : 0);
    if (a_tx_start) a_log.push_back(a_tx_data);
    if (b_tx_start) b_log.push_back(b_tx_data);
  end
  assign a_busy = a_bc != 0;
  assign b_busy = b_bc != 0;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic a_rx(input logic [7:0] d);
    a_rx_valid = 1'b1;
    a_rx_data = d;
    step();
    a_rx_valid = 1'b0;
  endtask
  task automatic a_pulse_play();
    a_play = 1'b1;
    step();
    a_play = 1'b0;
  endtask
  task automatic a_pulse_clr();
    a_clr = 1'b1;
    step();
    a_clr = 1'b0;
  endtask
  task automatic a_wait_idle(input string tag);
    for (int i = 0; i < 300 && a_playing; i++) step();
    check(tag, {31'd0, a_playing}, 32'd0);
  endtask
  task automatic a_check_log(input string tag, input logic [31:0] n, input logic [31:0] packed_exp);
    check({tag, "_n"}, a_log.size(), n);
    for (int i = 0; i < n && i < a_log.size(); i++)
      check($sformatf("%s_b%0d", tag, i), {24'd0, a_log[i]}, {24'd0, packed_exp[31-8*i -: 8]});
  endtask
  initial begin
    step();
    step();
    rst = 1'b0;
    check("rst_count", {29'd0, a_count}, 32'd0);
    check("rst_tx_start", {31'd0, a_tx_start}, 32'd0);
    check("rst_tx_data", {24'd0, a_tx_data}, 32'd0);
    check("rst_full", {31'd0, a_full}, 32'd0);
    check("rst_ovf", {31'd0, a_ovf}, 32'd0);
    check("rst_playing", {31'd0, a_playing}, 32'd0);
    // fill and replay
    a_rx(8'h11); a_rx(8'h22); a_rx(8'h33); a_rx(8'h44);
    check("fill_count", {29'd0, a_count}, 32'd4);
    check("fill_full", {31'd0, a_full}, 32'd1);
    a_pulse_play();
    check("lat_playing", {31'd0, a_playing}, 32'd1);
    check("lat_no_start", {31'd0, a_tx_start}, 32'd0);
    step();
    check("lat_start", {31'd0, a_tx_start}, 32'd1);
    check("lat_data", {24'd0, a_tx_data}, 32'h11);
    step();
    check("start_one_cycle", {31'd0, a_tx_start}, 32'd0);
    a_wait_idle("fill_idle");
    a_check_log("fill", 4, 32'h11223344);
    check("fill_count_after", {29'd0, a_count}, 32'd0);
    check("fill_full_after", {31'd0, a_full}, 32'd0);
    // overflow
    a_log.delete();
    a_pulse_clr();
    a_rx(8'hA0); a_rx(8'hA1); a_rx(8'hA2); a_rx(8'hA3); a_rx(8'hA4);
    check("ovf_count", {29'd0, a_count}, 32'd4);
    check("ovf_full", {31'd0, a_full}, 32'd1);
    check("ovf_flag", {31'd0, a_ovf}, 32'd1);
    a_pulse_play();
    a_wait_idle("ovf_idle");
    a_check_log("ovf", 4, 32'hA0A1A2A3);
    // partial frame, then play on empty frame
    a_log.delete();
    a_pulse_clr();
    check("clr_ovf", {31'd0, a_ovf}, 32'd0);
    a_rx(8'h7E); a_rx(8'h7F);
    a_pulse_play();
    a_wait_idle("part_idle");
    a_check_log("part", 2, 32'h7E7F0000);
    a_pulse_play();
    check("empty_play", {31'd0, a_playing}, 32'd0);
    for (int i = 0; i < 5; i++) step();
    check("empty_no_tx", a_log.size(), 32'd2);
    // byte arriving with play is included in the replay
    a_log.delete();
    a_play = 1'b1;
    a_rx(8'h66);
    a_play = 1'b0;
    check("same_cycle_playing", {31'd0, a_playing}, 32'd1);
    a_wait_idle("same_idle");
    a_check_log("same", 1, 32'h66000000);
    // clear during WAIT of byte 1
    a_log.delete();
    a_rx(8'h11); a_rx(8'h22); a_rx(8'h33);
    a_pulse_play();
    for (int i = 0; i < 100 && a_log.size() < 2; i++) step();
    check("mid_reached", a_log.size(), 32'd2);
    a_rx(8'hEE);
    check("busy_rx_ovf", {31'd0, a_ovf}, 32'd1);
    check("busy_rx_count", {29'd0, a_count}, 32'd3);
    a_pulse_clr();
    check("mid_count", {29'd0, a_count}, 32'd0);
    check("mid_ovf", {31'd0, a_ovf}, 32'd0);
    check("mid_playing", {31'd0, a_playing}, 32'd0);
    for (int i = 0; i < 30; i++) step();
    check("mid_no_more_tx", a_log.size(), 32'd2);
    // clr beats a simultaneous rx_valid
    a_rx(8'h01);
    a_clr = 1'b1;
    a_rx(8'h02);
    a_clr = 1'b0;
    check("clr_rx_count", {29'd0, a_count}, 32'd0);
    check("clr_rx_ovf", {31'd0, a_ovf}, 32'd0);
    // reset during SEND
    a_log.delete();
    a_rx(8'h55);
    a_pulse_play();
    check("pre_rst_playing", {31'd0, a_playing}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_send_start", {31'd0, a_tx_start}, 32'd0);
    check("rst_send_data", {24'd0, a_tx_data}, 32'd0);
    check("rst_send_count", {29'd0, a_count}, 32'd0);
    check("rst_send_playing", {31'd0, a_playing}, 32'd0);
    check("rst_send_full", {31'd0, a_full}, 32'd0);
    for (int i = 0; i < 5; i++) step();
    check("rst_send_no_tx", a_log.size(), 32'd0);
    // auto-play on a 2-byte frame
    b_rx_valid = 1'b1;
    b_rx_data = 8'h01;
    step();
    b_rx_data = 8'h02;
    step();
    b_rx_valid = 1'b0;
    check("auto_playing", {31'd0, b_playing}, 32'd1);
    check("auto_no_start", {31'd0, b_tx_start}, 32'd0);
    step();
    check("auto_start", {31'd0, b_tx_start}, 32'd1);
    check("auto_data", {24'd0, b_tx_data}, 32'h01);
    for (int i = 0; i < 300 && b_playing; i++) step();
    check("auto_idle", {31'd0, b_playing}, 32'd0);
    check("auto_n", b_log.size(), 32'd2);
    if (b_log.size() == 2) begin
      check("auto_b0", {24'd0, b_log[0]}, 32'h01);
      check("auto_b1", {24'd0, b_log[1]}, 32'h02);
    end
    check("auto_count", {30'd0, b_count}, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
